// File: rtl/cpu_mem_pkg.sv
// Shared widths, FSM state encoding and port identifiers for the core-to-memory arbiter.
package cpu_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Port ids double as bit positions in the req/grant vectors.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/arb2_rr.sv
// 2-way round-robin arbiter: one-hot grant among req[1:0] while the slot is open.
// Latency: combinational grant; lastGrant updates on the edge that consumes a grant.
// Backpressure: no grant while slotEn is low; requesters simply hold their request.
module arb2_rr
  import cpu_mem_pkg::*;
#(
  parameter logic INIT_LAST = PORT_FETCH
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [1:0] req,
  input  logic       slotEn,
  output logic [1:0] grant
);

  logic lastGrant;

  always_comb begin
    grant = 2'b00;
    if (slotEn) begin
      if (req == 2'b11) begin
        grant = (lastGrant == PORT_DATA) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  // Every grant is taken by its requester, so any grant is an accept.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      lastGrant <= INIT_LAST;
    end else if (|grant) begin
      lastGrant <= grant[PORT_DATA];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store ports onto one 256x16 memory, one access per command.
// Latency: accept at edge N -> memory access in cycle N+1 -> Valid pulse in cycle N+2.
// Backpressure: Ready only in IDLE/RESP for the winning requester; requests hold until Ready.
module mem_bus_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W     = cpu_mem_pkg::DATA_W,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchReady,
  output logic              fetchValid,
  output logic [DATA_W-1:0] fetchData,
  input  logic              dataReq,
  input  logic              dataWrite,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataReady,
  output logic              dataValid,
  output logic [DATA_W-1:0] dataRdata,
  output logic              memEnable,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData
);

  localparam logic INIT_LAST = DATA_FIRST ? PORT_FETCH : PORT_DATA;

  state_t            state;
  logic              cmdPort;
  logic              cmdWrite;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdWdata;

  logic       slotEn;
  logic       inAccess;
  logic       accept;
  logic [1:0] grant;

  assign inAccess = (state == ACCESS);
  // Reset gating keeps Ready low while resetN is held, even though state is already IDLE.
  assign slotEn   = resetN && !inAccess;

  arb2_rr #(
    .INIT_LAST(INIT_LAST)
  ) u_arb (
    .clock (clock),
    .resetN(resetN),
    .req   ({dataReq, fetchReq}),
    .slotEn(slotEn),
    .grant (grant)
  );

  assign fetchReady = grant[PORT_FETCH];
  assign dataReady  = grant[PORT_DATA];
  assign accept     = |grant;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      cmdPort    <= PORT_FETCH;
      cmdWrite   <= 1'b0;
      cmdAddr    <= '0;
      cmdWdata   <= '0;
      fetchValid <= 1'b0;
      dataValid  <= 1'b0;
      fetchData  <= '0;
      dataRdata  <= '0;
    end else begin
      fetchValid <= 1'b0;
      dataValid  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            state    <= ACCESS;
            cmdPort  <= dataReady ? PORT_DATA : PORT_FETCH;
            cmdWrite <= dataReady && dataWrite;
            cmdAddr  <= dataReady ? dataAddr : fetchAddr;
            cmdWdata <= dataReady ? dataWdata : '0;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (cmdPort == PORT_DATA) begin
            dataValid <= 1'b1;
            dataRdata <= cmdWrite ? '0 : memReadData;
          end else begin
            fetchValid <= 1'b1;
            fetchData  <= memReadData;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory bus is idle-zero outside ACCESS; fetch commands can never write.
  assign memEnable      = inAccess;
  assign memWriteEnable = inAccess && cmdWrite && (cmdPort == PORT_DATA);
  assign memAddress     = inAccess ? cmdAddr : '0;
  assign memWriteData   = inAccess ? cmdWdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + randomized bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        resetN;
  logic        fetchReq;
  logic [7:0]  fetchAddr;
  logic        fetchReady;
  logic        fetchValid;
  logic [15:0] fetchData;
  logic        dataReq;
  logic        dataWrite;
  logic [7:0]  dataAddr;
  logic [15:0] dataWdata;
  logic        dataReady;
  logic        dataValid;
  logic [15:0] dataRdata;
  logic        memEnable;
  logic        memWriteEnable;
  logic [7:0]  memAddress;
  logic [15:0] memWriteData;
  logic [15:0] memReadData;

  logic [15:0] mem    [256];
  logic [15:0] refMem [256];

  int tests  = 0;
  int failed = 0;

  // Reference model state: a command is either in flight (busy) or the slot is open.
  bit          busy;
  bit          cur_data;
  bit          cur_w;
  logic [7:0]  cur_a;
  logic [15:0] cur_d;
  bit          rv_f, rv_d;
  logic [15:0] e_fdata, e_rdata;
  bit          last_data;
  bit          acc_f, acc_d;
  bit          grants[$];
  int          dvalid_cnt;

  always #5 clock = ~clock;

  assign memReadData = mem[memAddress];

  mem_bus_arbiter #(
    .ADDR_W(8),
    .DATA_W(16),
    .DATA_FIRST(1'b1)
  ) dut (
    .clock         (clock),
    .resetN        (resetN),
    .fetchReq      (fetchReq),
    .fetchAddr     (fetchAddr),
    .fetchReady    (fetchReady),
    .fetchValid    (fetchValid),
    .fetchData     (fetchData),
    .dataReq       (dataReq),
    .dataWrite     (dataWrite),
    .dataAddr      (dataAddr),
    .dataWdata     (dataWdata),
    .dataReady     (dataReady),
    .dataValid     (dataValid),
    .dataRdata     (dataRdata),
    .memEnable     (memEnable),
    .memWriteEnable(memWriteEnable),
    .memAddress    (memAddress),
    .memWriteData  (memWriteData),
    .memReadData   (memReadData)
  );

  function automatic logic [15:0] initw(input int i);
    logic [15:0] v;
    v = 16'(i * 257) ^ 16'h5A5A;
    if (i == 16'h10) v = 16'hABCD;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    bit          wf, wd, wp;
    logic [7:0]  wa;
    logic [15:0] wdat;
    #1;
    wd = !busy && dataReq && (!fetchReq || !last_data);
    wf = !busy && fetchReq && !wd;
    chk("fetchReady", fetchReady, wf);
    chk("dataReady", dataReady, wd);
    chk("memEnable", memEnable, busy);
    chk("memWriteEnable", memWriteEnable, busy && cur_data && cur_w);
    chk("memAddress", memAddress, busy ? cur_a : 8'h00);
    chk("memWriteData", memWriteData, busy ? cur_d : 16'h0000);
    chk("fetchValid", fetchValid, rv_f);
    chk("dataValid", dataValid, rv_d);
    chk("fetchData", fetchData, e_fdata);
    chk("dataRdata", dataRdata, e_rdata);
    if (dataReady) grants.push_back(1'b1);
    else if (fetchReady) grants.push_back(1'b0);
    if (dataValid) dvalid_cnt++;
    wp   = memEnable && memWriteEnable;
    wa   = memAddress;
    wdat = memWriteData;
    @(posedge clock);
    if (wp) mem[wa] = wdat;
    rv_f = 0;
    rv_d = 0;
    if (busy) begin
      if (cur_data) begin
        if (cur_w) begin
          refMem[cur_a] = cur_d;
          e_rdata = 16'h0000;
        end else begin
          e_rdata = refMem[cur_a];
        end
        rv_d = 1;
      end else begin
        e_fdata = refMem[cur_a];
        rv_f = 1;
      end
      busy = 0;
    end
    if (wd || wf) begin
      busy      = 1;
      cur_data  = wd;
      cur_w     = wd && dataWrite;
      cur_a     = wd ? dataAddr : fetchAddr;
      cur_d     = wd ? dataWdata : 16'h0000;
      last_data = wd;
    end
    acc_f = wf;
    acc_d = wd;
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    chk("rst memEnable", memEnable, 1'b0);
    chk("rst memWriteEnable", memWriteEnable, 1'b0);
    chk("rst memAddress", memAddress, 8'h00);
    chk("rst memWriteData", memWriteData, 16'h0000);
    chk("rst fetchReady", fetchReady, 1'b0);
    chk("rst dataReady", dataReady, 1'b0);
    chk("rst fetchValid", fetchValid, 1'b0);
    chk("rst dataValid", dataValid, 1'b0);
    chk("rst fetchData", fetchData, 16'h0000);
    chk("rst dataRdata", dataRdata, 16'h0000);
    busy      = 0;
    rv_f      = 0;
    rv_d      = 0;
    e_fdata   = 16'h0000;
    e_rdata   = 16'h0000;
    last_data = 0;
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic idle(input int n);
    fetchReq = 1'b0;
    dataReq  = 1'b0;
    repeat (n) cycle();
  endtask

  function automatic logic [7:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
  endfunction

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = initw(i);
      refMem[i] = initw(i);
    end
    resetN     = 1'b1;
    fetchReq   = 1'b1;
    fetchAddr  = 8'h31;
    dataReq    = 1'b1;
    dataWrite  = 1'b0;
    dataAddr   = 8'h30;
    dataWdata  = 16'h0000;
    dvalid_cnt = 0;

    // Reset with both requests held, then six contended grants must alternate D,F,D,F,D,F.
    #2;
    do_reset();
    grants.delete();
    for (int i = 0; i < 40 && grants.size() < 6; i++) cycle();
    chk("alt grant count", grants.size(), 6);
    for (int i = 0; i < grants.size() && i < 6; i++)
      chk($sformatf("alt grant %0d is data", i), grants[i], (i % 2) == 0);
    idle(3);

    // Single fetch from 0x10.
    fetchReq  = 1'b1;
    fetchAddr = 8'h10;
    cycle();
    idle(3);
    chk("fetch 0x10 data", fetchData, 16'hABCD);

    // Store 0x1234 to 0x20, then load it back immediately.
    d0        = dvalid_cnt;
    dataReq   = 1'b1;
    dataWrite = 1'b1;
    dataAddr  = 8'h20;
    dataWdata = 16'h1234;
    cycle();
    dataWrite = 1'b0;
    dataWdata = 16'h0000;
    cycle();
    cycle();
    idle(3);
    chk("store/load valid count", dvalid_cnt - d0, 2);
    chk("load after store", dataRdata, 16'h1234);

    // Reset pulse while a store is on the memory bus.
    dataReq   = 1'b1;
    dataWrite = 1'b1;
    dataAddr  = 8'h40;
    dataWdata = 16'hBEEF;
    cycle();
    dataReq = 1'b0;
    #1;
    chk("store in access", memWriteEnable, 1'b1);
    do_reset();
    idle(3);
    chk("aborted store mem", mem[8'h40], initw(8'h40));
    fetchReq  = 1'b1;
    fetchAddr = 8'h05;
    cycle();
    idle(3);

    // Interleaved fetch at 0xFF and load at 0x00.
    fetchReq  = 1'b1;
    fetchAddr = 8'hFF;
    dataReq   = 1'b1;
    dataWrite = 1'b0;
    dataAddr  = 8'h00;
    grants.delete();
    for (int i = 0; i < 30 && grants.size() < 4; i++) cycle();
    idle(3);
    chk("interleave grants", grants.size(), 4);
    chk("fetch 0xFF data", fetchData, initw(8'hFF));
    chk("load 0x00 data", dataRdata, initw(8'h00));

    // Randomized traffic; requests may drop before acceptance.
    fetchReq = 1'b0;
    dataReq  = 1'b0;
    acc_f    = 0;
    acc_d    = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(fetchReq && !acc_f && $urandom_range(0, 3) != 0)) begin
        fetchReq  = $urandom_range(0, 1) == 1;
        fetchAddr = rand_addr();
      end
      if (!(dataReq && !acc_d && $urandom_range(0, 3) != 0)) begin
        dataReq   = $urandom_range(0, 1) == 1;
        dataWrite = $urandom_range(0, 1) == 1;
        dataAddr  = rand_addr();
        dataWdata = 16'($urandom);
      end
      cycle();
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
